// File: rtl/fila_pkg.sv
// ============================================================================
// Module      : fila_pkg
// Description : Shared types and sizing for the circular instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fila_pkg;

  localparam int LARGURA_INSTR     = 16;
  localparam int PROFUNDIDADE_FILA = 8;

  typedef logic [LARGURA_INSTR-1:0] instr_t;

  // Opcode field location inside an instruction word.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_de(input instr_t instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_fila.sv
// ============================================================================
// Module      : ram_fila
// Description : Queue storage, one synchronous write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fila
  import fila_pkg::*;
#(
  parameter int LARGURA      = LARGURA_INSTR,
  parameter int PROFUNDIDADE = PROFUNDIDADE_FILA,
  parameter int ADDR_W       = $clog2(PROFUNDIDADE)
) (
  input  logic              clock,
  input  logic              grava,
  input  logic [ADDR_W-1:0] end_escrita,
  input  logic [LARGURA-1:0] dado_escrita,
  input  logic [ADDR_W-1:0] end_leitura,
  output logic [LARGURA-1:0] dado_leitura
);

  // Contents are intentionally not reset; validity is tracked by the pointers.
  logic [LARGURA-1:0] mem [PROFUNDIDADE];

  always_ff @(posedge clock) begin
    if (grava) begin
      mem[end_escrita] <= dado_escrita;
    end
  end

  assign dado_leitura = mem[end_leitura];

endmodule

`default_nettype wire

// File: rtl/fila_instrucao_circular.sv
// ============================================================================
// Module      : fila_instrucao_circular
// Description : Circular FWFT instruction queue between fetch and dispatch.
//               Optional macro FILA_BYPASS_EN adds an empty-queue bypass path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fila_instrucao_circular
  import fila_pkg::*;
#(
  parameter int LARGURA      = LARGURA_INSTR,
  parameter int PROFUNDIDADE = PROFUNDIDADE_FILA
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           escreve,
  input  logic [LARGURA-1:0]             instrucao_in,
  input  logic                           despacha,
  input  logic                           descarta,
  output logic [LARGURA-1:0]             instrucao,
  output logic                           valida,
  output logic                           cheia,
  output logic                           vazia,
  output logic [$clog2(PROFUNDIDADE):0]  ocupacao,
  output logic                           erro_overflow
);

  localparam int ADDR_W = $clog2(PROFUNDIDADE);
  localparam logic [ADDR_W:0] PTR_UM    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] OCUP_MAX  = (ADDR_W+1)'(PROFUNDIDADE);

  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_ptr;
  logic [ADDR_W:0]    ocup;
  logic               fila_vazia;
  logic               fila_cheia;
  logic               bypass;
  logic               pop_ok;
  logic               consome_direto;
  logic               avanca_wr;
  logic               avanca_rd;
  logic               overflow;
  logic [LARGURA-1:0] dado_cabeca;

  // Occupancy wraps modulo 2^(ADDR_W+1); the extra MSB separates full from empty.
  assign ocup       = wr_ptr - rd_ptr;
  assign fila_vazia = (ocup == '0);
  assign fila_cheia = (ocup == OCUP_MAX);

  always_comb begin
    bypass = 1'b0;
`ifdef FILA_BYPASS_EN
    bypass = fila_vazia && escreve && !descarta;
`endif
    valida         = !fila_vazia || bypass;
    pop_ok         = despacha && valida;
    // A bypassed word that is dispatched at once never touches storage.
    consome_direto = bypass && pop_ok;
    avanca_wr      = escreve && (!fila_cheia || pop_ok) && !descarta && !consome_direto;
    avanca_rd      = pop_ok && !descarta && !consome_direto;
    overflow       = escreve && fila_cheia && !pop_ok && !descarta;

    instrucao = '0;
    if (!fila_vazia) begin
      instrucao = dado_cabeca;
    end else if (bypass) begin
      instrucao = instrucao_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      erro_overflow <= 1'b0;
    end else begin
      if (descarta) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (avanca_wr) wr_ptr <= wr_ptr + PTR_UM;
        if (avanca_rd) rd_ptr <= rd_ptr + PTR_UM;
      end
      if (overflow) erro_overflow <= 1'b1;
    end
  end

  ram_fila #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE),
    .ADDR_W       (ADDR_W)
  ) u_ram (
    .clock        (clock),
    .grava        (avanca_wr),
    .end_escrita  (wr_ptr[ADDR_W-1:0]),
    .dado_escrita (instrucao_in),
    .end_leitura  (rd_ptr[ADDR_W-1:0]),
    .dado_leitura (dado_cabeca)
  );

  assign cheia    = fila_cheia;
  assign vazia    = fila_vazia;
  assign ocupacao = ocup;

endmodule

`default_nettype wire

// File: tb/tb_fila_instrucao_circular.sv
// ============================================================================
// Module      : tb_fila_instrucao_circular
// Description : Directed and random checks of the queue against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fila_instrucao_circular;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        escreve = 1'b0;
  logic [15:0] instrucao_in = '0;
  logic        despacha = 1'b0;
  logic        descarta = 1'b0;
  logic [15:0] instrucao;
  logic        valida;
  logic        cheia;
  logic        vazia;
  logic [3:0]  ocupacao;
  logic        erro_overflow;

  fila_instrucao_circular dut (
    .clock         (clock),
    .reset         (reset),
    .escreve       (escreve),
    .instrucao_in  (instrucao_in),
    .despacha      (despacha),
    .descarta      (descarta),
    .instrucao     (instrucao),
    .valida        (valida),
    .cheia         (cheia),
    .vazia         (vazia),
    .ocupacao      (ocupacao),
    .erro_overflow (erro_overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue plus the sticky error bit.
  logic [15:0] q[$];
  bit          m_err = 0;
  bit          model_ok = 0;

  task automatic chk(input string nome, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nome, got, exp, $time);
    end
  endtask

  function automatic bit bypass_on(input logic e, input logic f);
`ifdef FILA_BYPASS_EN
    return (q.size() == 0) && e && !f;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_check(input logic e, input logic [15:0] d, input logic f);
    bit          byp;
    logic [15:0] exp_i;
    byp   = bypass_on(e, f);
    exp_i = (q.size() != 0) ? q[0] : (byp ? d : 16'h0000);
    chk("valida",        {15'd0, valida},        {15'd0, (q.size() != 0) || byp});
    chk("instrucao",     instrucao,              exp_i);
    chk("ocupacao",      {12'd0, ocupacao},      16'(q.size()));
    chk("cheia",         {15'd0, cheia},         {15'd0, q.size() == 8});
    chk("vazia",         {15'd0, vazia},         {15'd0, q.size() == 0});
    chk("erro_overflow", {15'd0, erro_overflow}, {15'd0, m_err});
  endtask

  task automatic model_update(input logic e, input logic [15:0] d, input logic p,
                              input logic f, input logic r);
    bit byp, pop, push, full;
    if (r) begin
      q.delete();
      m_err    = 0;
      model_ok = 1;
    end else if (f) begin
      q.delete();
    end else begin
      byp  = bypass_on(e, f);
      pop  = p && ((q.size() != 0) || byp);
      full = (q.size() == 8);
      if (!(byp && pop)) begin
        push = e && (!full || pop);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d);
        if (e && full && !pop) m_err = 1;
      end
    end
  endtask

  // One clock cycle: drive, check before the edge, update model, idle at negedge.
  task automatic step(input logic e, input logic [15:0] d, input logic p,
                      input logic f, input logic r);
    escreve = e; instrucao_in = d; despacha = p; descarta = f; reset = r;
    #1;
    if (model_ok) model_check(e, d, f);
    @(posedge clock);
    model_update(e, d, p, f, r);
    @(negedge clock);
    escreve = 0; despacha = 0; descarta = 0; reset = 0;
    #1;
  endtask

  initial begin
    // Reset
    step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 1);
    chk("rst_ocupacao", {12'd0, ocupacao}, 16'd0);
    chk("rst_vazia",    {15'd0, vazia},    16'd1);
    chk("rst_valida",   {15'd0, valida},   16'd0);
    chk("rst_instr",    instrucao,         16'h0000);
    chk("rst_err",      {15'd0, erro_overflow}, 16'd0);

    // In-order push/pop
    step(1, 16'h0CA0, 0, 0, 0);
    step(1, 16'h5590, 0, 0, 0);
    step(1, 16'h1660, 0, 0, 0);
    chk("t1_ocup3", {12'd0, ocupacao}, 16'd3);
    chk("t1_head0", instrucao, 16'h0CA0);
    step(0, 16'h0, 1, 0, 0);
    chk("t1_head1", instrucao, 16'h5590);
    step(0, 16'h0, 1, 0, 0);
    chk("t1_head2", instrucao, 16'h1660);
    step(0, 16'h0, 1, 0, 0);
    chk("t1_vazia", {15'd0, vazia}, 16'd1);

    // Fill and overflow
    for (int i = 0; i < 8; i++) step(1, 16'h1000 + 16'(i), 0, 0, 0);
    chk("t2_cheia", {15'd0, cheia}, 16'd1);
    chk("t2_err0",  {15'd0, erro_overflow}, 16'd0);
    step(1, 16'hDEAD, 0, 0, 0);
    chk("t2_err1",  {15'd0, erro_overflow}, 16'd1);
    chk("t2_ocup8", {12'd0, ocupacao}, 16'd8);

    // Push + pop at full, then drain across the wrap
    step(1, 16'hAAAA, 1, 0, 0);
    chk("t3_ocup8", {12'd0, ocupacao}, 16'd8);
    for (int i = 1; i < 8; i++) begin
      chk("t3_head", instrucao, 16'h1000 + 16'(i));
      step(0, 16'h0, 1, 0, 0);
    end
    chk("t3_aaaa", instrucao, 16'hAAAA);
    step(0, 16'h0, 1, 0, 0);
    chk("t3_vazia", {15'd0, vazia}, 16'd1);

    // Flush beats a same-cycle push
    for (int i = 0; i < 5; i++) step(1, 16'h2000 + 16'(i), 0, 0, 0);
    step(1, 16'h7777, 0, 1, 0);
    chk("t4_vazia",  {15'd0, vazia},  16'd1);
    chk("t4_ocup",   {12'd0, ocupacao}, 16'd0);
    chk("t4_valida", {15'd0, valida}, 16'd0);
    chk("t4_err",    {15'd0, erro_overflow}, 16'd1);
    step(1, 16'h1234, 0, 0, 0);
    chk("t4_head",   instrucao, 16'h1234);
    step(0, 16'h0, 1, 0, 0);

    // Pop on empty, then push+pop on empty
    step(0, 16'h0, 1, 0, 0);
    chk("t5_ocup0", {12'd0, ocupacao}, 16'd0);
    escreve = 1; instrucao_in = 16'h8AB0; despacha = 1;
    #1;
`ifdef FILA_BYPASS_EN
    chk("t5_byp_instr", instrucao, 16'h8AB0);
    chk("t5_byp_valida", {15'd0, valida}, 16'd1);
`else
    chk("t5_nobyp_instr", instrucao, 16'h0000);
    chk("t5_nobyp_valida", {15'd0, valida}, 16'd0);
`endif
    step(1, 16'h8AB0, 1, 0, 0);
`ifdef FILA_BYPASS_EN
    chk("t5_ocup_after", {12'd0, ocupacao}, 16'd0);
`else
    chk("t5_ocup_after", {12'd0, ocupacao}, 16'd1);
    chk("t5_head_after", instrucao, 16'h8AB0);
`endif
    step(0, 16'h0, 1, 0, 0);

    // Reset mid-stream with a push in flight
    for (int i = 0; i < 4; i++) step(1, 16'h4000 + 16'(i), 0, 0, 0);
    step(1, 16'h4444, 0, 0, 1);
    chk("t6_ocup",   {12'd0, ocupacao}, 16'd0);
    chk("t6_vazia",  {15'd0, vazia},    16'd1);
    chk("t6_cheia",  {15'd0, cheia},    16'd0);
    chk("t6_valida", {15'd0, valida},   16'd0);
    chk("t6_instr",  instrucao,         16'h0000);
    chk("t6_err",    {15'd0, erro_overflow}, 16'd0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      logic e, p, f, r;
      e = ($urandom_range(0, 99) < 55);
      p = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 499) < 2);
      step(e, 16'($urandom), p, f, r);
    end
    model_check(1'b0, 16'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
